// File: rtl/mem_access_unit.sv
// MEM-stage memory access unit: issues one load/store per instruction as a valid/ready
// data-cache transaction, stalls the pipeline until it completes and extends load results.
module mem_access_unit #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                mem_read_in,
  input  logic                mem_write_in,
  input  logic [ADDR_W-1:0]   addr_in,
  input  logic [XLEN-1:0]     wdata_in,
  input  logic [1:0]          size_in,
  input  logic                unsigned_in,
  output logic                dc_req_valid,
  input  logic                dc_req_ready,
  output logic                dc_req_we,
  output logic [ADDR_W-1:0]   dc_req_addr,
  output logic [XLEN-1:0]     dc_req_wdata,
  output logic [XLEN/8-1:0]   dc_req_strb,
  input  logic                dc_resp_valid,
  input  logic [XLEN-1:0]     dc_resp_rdata,
  output logic                stall_out,
  output logic                load_valid,
  output logic [XLEN-1:0]     load_data,
  output logic                misalign_out
);

  localparam int unsigned StrbW = XLEN / 8;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [2:0]          off_q, off_d;
  logic [1:0]          size_q, size_d;
  logic                unsigned_q, unsigned_d;
  logic                we_q, we_d;
  logic                kill_q, kill_d;
  logic                req_valid_q, req_valid_d;
  logic                req_we_q, req_we_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [XLEN-1:0]     req_wdata_q, req_wdata_d;
  logic [StrbW-1:0]    req_strb_q, req_strb_d;
  logic                load_valid_q, load_valid_d;
  logic [XLEN-1:0]     load_data_q, load_data_d;
  logic                misalign_q, misalign_d;

  logic                req_present;
  logic                misaligned;
  logic [StrbW-1:0]    strb_base;
  logic [XLEN-1:0]     resp_shifted;
  logic [XLEN-1:0]     load_ext;

  assign req_present = (mem_read_in | mem_write_in) & ~flush;

  // Alignment check and unshifted byte-enable pattern for the incoming request.
  always_comb begin
    misaligned = 1'b0;
    strb_base  = StrbW'(8'h01);
    case (size_in)
      2'd0: begin
        misaligned = 1'b0;
        strb_base  = StrbW'(8'h01);
      end
      2'd1: begin
        misaligned = addr_in[0];
        strb_base  = StrbW'(8'h03);
      end
      2'd2: begin
        misaligned = |addr_in[1:0];
        strb_base  = StrbW'(8'h0F);
      end
      default: begin
        misaligned = |addr_in[2:0];
        strb_base  = StrbW'(8'hFF);
      end
    endcase
  end

  // Byte-lane select and sign/zero extension of the cache response.
  always_comb begin
    resp_shifted = dc_resp_rdata >> {off_q, 3'b000};
    load_ext     = resp_shifted;
    case (size_q)
      2'd0:    load_ext = {{(XLEN-8){~unsigned_q & resp_shifted[7]}}, resp_shifted[7:0]};
      2'd1:    load_ext = {{(XLEN-16){~unsigned_q & resp_shifted[15]}}, resp_shifted[15:0]};
      2'd2:    load_ext = {{(XLEN-32){~unsigned_q & resp_shifted[31]}}, resp_shifted[31:0]};
      default: load_ext = resp_shifted;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    we_d         = we_q;
    kill_d       = kill_q;
    req_valid_d  = req_valid_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    req_strb_d   = req_strb_q;
    load_valid_d = 1'b0;
    load_data_d  = load_data_q;
    misalign_d   = 1'b0;
    stall_out    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_present) begin
          stall_out  = 1'b1;
          off_d      = addr_in[2:0];
          size_d     = size_in;
          unsigned_d = unsigned_in;
          we_d       = ~mem_read_in;
          if (misaligned) begin
            state_d    = StDone;
            misalign_d = 1'b1;
          end else begin
            state_d     = StReq;
            req_valid_d = 1'b1;
            req_we_d    = ~mem_read_in;
            req_addr_d  = {addr_in[ADDR_W-1:3], 3'b000};
            req_wdata_d = wdata_in << {addr_in[2:0], 3'b000};
            req_strb_d  = strb_base << addr_in[2:0];
          end
        end
      end
      StReq: begin
        stall_out = 1'b1;
        if (flush) kill_d = 1'b1;
        // Valid is held until the handshake, even when the instruction has been killed.
        if (dc_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = we_q ? StDone : StWait;
        end
      end
      StWait: begin
        stall_out = 1'b1;
        if (flush) kill_d = 1'b1;
        if (dc_resp_valid) begin
          state_d = StDone;
          if (!(kill_q | flush)) begin
            load_valid_d = 1'b1;
            load_data_d  = load_ext;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        kill_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      off_q        <= '0;
      size_q       <= '0;
      unsigned_q   <= 1'b0;
      we_q         <= 1'b0;
      kill_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_strb_q   <= '0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      we_q         <= we_d;
      kill_q       <= kill_d;
      req_valid_q  <= req_valid_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      req_strb_q   <= req_strb_d;
      load_valid_q <= load_valid_d;
      load_data_q  <= load_data_d;
      misalign_q   <= misalign_d;
    end
  end

  assign dc_req_valid = req_valid_q;
  assign dc_req_we    = req_we_q;
  assign dc_req_addr  = req_addr_q;
  assign dc_req_wdata = req_wdata_q;
  assign dc_req_strb  = req_strb_q;
  assign load_valid   = load_valid_q;
  assign load_data    = load_data_q;
  assign misalign_out = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table of transactions, randomized transactions against
// an arithmetic reference model, and hand-written reset/idle-response sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic [63:0] addr_in = '0;
  logic [63:0] wdata_in = '0;
  logic [1:0]  size_in = '0;
  logic        unsigned_in = 1'b0;
  logic        dc_req_valid;
  logic        dc_req_ready = 1'b0;
  logic        dc_req_we;
  logic [63:0] dc_req_addr;
  logic [63:0] dc_req_wdata;
  logic [7:0]  dc_req_strb;
  logic        dc_resp_valid = 1'b0;
  logic [63:0] dc_resp_rdata = '0;
  logic        stall_out;
  logic        load_valid;
  logic [63:0] load_data;
  logic        misalign_out;

  mem_access_unit #(.XLEN(64), .ADDR_W(64)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .addr_in(addr_in), .wdata_in(wdata_in), .size_in(size_in), .unsigned_in(unsigned_in),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_we(dc_req_we),
    .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata), .dc_req_strb(dc_req_strb),
    .dc_resp_valid(dc_resp_valid), .dc_resp_rdata(dc_resp_rdata),
    .stall_out(stall_out), .load_valid(load_valid), .load_data(load_data),
    .misalign_out(misalign_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [63:0] addr, wdata;
    logic [1:0]  size;
    logic        uns;
    int          ready_dly, resp_dly, flush_at;
    logic [63:0] rdata;
    int          exp_stall, exp_req;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
    logic        exp_lv;
    logic [63:0] exp_ld;
    logic        exp_mis;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  int          obs_stall, obs_req;
  logic        obs_lv, obs_mis, stable;
  logic [63:0] obs_ld, f_addr, f_wdata;
  logic        f_we;
  logic [7:0]  f_strb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic rd, input logic wr, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [1:0] size, input logic uns,
                               input int rdy, input int rsp, input int fl, input logic [63:0] rdata,
                               input int stall, input int req, input logic [7:0] strb,
                               input logic [63:0] wd, input logic lv, input logic [63:0] ld,
                               input logic mis);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
    v.ready_dly = rdy; v.resp_dly = rsp; v.flush_at = fl; v.rdata = rdata;
    v.exp_stall = stall; v.exp_req = req; v.exp_strb = strb; v.exp_wdata = wd;
    v.exp_lv = lv; v.exp_ld = ld; v.exp_mis = mis;
    return v;
  endfunction

  // Reference model: expectations straight from the access rules, using plain arithmetic.
  function automatic vec_t model(input logic rd, input logic wr, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [1:0] size,
                                 input logic uns, input int rdy, input int rsp, input int fl,
                                 input logic [63:0] rdata);
    vec_t v;
    int unsigned off, nbytes, nbits;
    logic [63:0] mask, x;
    logic mis;
    off    = 32'(addr[2:0]);
    nbytes = 32'd1 << size;
    nbits  = 8 * nbytes;
    mis    = (addr % 64'(nbytes)) != 64'd0;
    x      = rdata >> (8 * off);
    if (nbits < 64) begin
      mask = (64'd1 << nbits) - 64'd1;
      x    = x & mask;
      if (!uns && x[nbits-1]) x = x | ~mask;
    end
    v = mkv(rd, wr, addr, wdata, size, uns, rdy, rsp, fl, rdata,
            mis ? 1 : (rd ? 3 + rdy + rsp : 2 + rdy), mis ? 0 : rdy + 1,
            8'(((32'd1 << nbytes) - 32'd1) << off), wdata << (8 * off),
            rd && !mis && fl < 0, x, mis);
    return v;
  endfunction

  task automatic idle_inputs();
    mem_read_in = 1'b0; mem_write_in = 1'b0; flush = 1'b0;
    dc_req_ready = 1'b0; dc_resp_valid = 1'b0;
  endtask

  // Drives one request and plays the cache side, observing until the first non-stall cycle.
  task automatic check_vec(input vec_t v, input string tag);
    int cyc, vcnt, wcnt;
    logic in_wait, done;
    obs_stall = 0; obs_req = 0; obs_lv = 1'b0; obs_mis = 1'b0; obs_ld = '0; stable = 1'b1;
    cyc = 0; vcnt = 0; wcnt = 0; in_wait = 1'b0; done = 1'b0;
    @(negedge clk);
    mem_read_in = v.rd; mem_write_in = v.wr; addr_in = v.addr; wdata_in = v.wdata;
    size_in = v.size; unsigned_in = v.uns;
    while (!done && cyc < 60) begin
      flush = (cyc == v.flush_at);
      dc_req_ready = dc_req_valid ? (vcnt >= v.ready_dly) : 1'($urandom);
      if (in_wait) begin
        dc_resp_valid = (wcnt >= v.resp_dly);
        dc_resp_rdata = v.rdata;
      end else begin
        dc_resp_valid = 1'($urandom);
        dc_resp_rdata = {$urandom, $urandom};
      end
      #1;
      if (dc_req_valid) begin
        if (obs_req == 0) begin
          f_addr = dc_req_addr; f_we = dc_req_we; f_strb = dc_req_strb; f_wdata = dc_req_wdata;
        end else if (dc_req_addr !== f_addr || dc_req_we !== f_we || dc_req_strb !== f_strb ||
                     dc_req_wdata !== f_wdata) begin
          stable = 1'b0;
        end
        obs_req++;
      end
      if (stall_out) obs_stall++;
      else begin
        done = 1'b1; obs_lv = load_valid; obs_ld = load_data; obs_mis = misalign_out;
      end
      if (in_wait) begin
        if (dc_resp_valid) in_wait = 1'b0;
        else wcnt++;
      end
      if (dc_req_valid) begin
        if (dc_req_ready) in_wait = v.rd;
        else vcnt++;
      end
      cyc++;
      if (!done) @(negedge clk);
    end
    if (!done) begin
      chk({tag, " timeout"}, 64'd0, 64'd1);
      idle_inputs();
      reset = 1'b1; #2; reset = 1'b0;
    end else begin
      chk({tag, " stall cycles"}, 64'(obs_stall), 64'(v.exp_stall));
      chk({tag, " valid cycles"}, 64'(obs_req), 64'(v.exp_req));
      if (v.exp_req > 0) begin
        chk({tag, " req addr"}, f_addr, v.addr & ~64'h7);
        chk({tag, " req we"}, 64'(f_we), 64'(v.wr && !v.rd));
        chk({tag, " req stable"}, 64'(stable), 64'd1);
        if (!v.rd) begin
          chk({tag, " req strb"}, 64'(f_strb), 64'(v.exp_strb));
          chk({tag, " req wdata"}, f_wdata, v.exp_wdata);
        end
      end
      chk({tag, " load_valid"}, 64'(obs_lv), 64'(v.exp_lv));
      if (v.exp_lv) chk({tag, " load_data"}, obs_ld, v.exp_ld);
      chk({tag, " misalign"}, 64'(obs_mis), 64'(v.exp_mis));
      @(negedge clk);
      idle_inputs();
      #1;
      chk({tag, " pulse end"}, {62'd0, load_valid, misalign_out}, 64'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " valid"}, 64'(dc_req_valid), 64'd0);
    chk({tag, " we/strb"}, {55'd0, dc_req_we, dc_req_strb}, 64'd0);
    chk({tag, " addr"}, dc_req_addr, 64'd0);
    chk({tag, " wdata"}, dc_req_wdata, 64'd0);
    chk({tag, " pulses/stall"}, {61'd0, load_valid, misalign_out, stall_out}, 64'd0);
    chk({tag, " load_data"}, load_data, 64'd0);
  endtask

  // Reset applied between clock edges while a load sits in REQ (in_req=1) or WAIT.
  task automatic reset_mid(input logic in_req, input string tag);
    @(negedge clk);
    mem_read_in = 1'b1; mem_write_in = 1'b0; addr_in = 64'hC008; wdata_in = 64'h55;
    size_in = 2'd3; unsigned_in = 1'b0; flush = 1'b0; dc_req_ready = 1'b0; dc_resp_valid = 1'b0;
    @(negedge clk);
    if (!in_req) begin
      dc_req_ready = 1'b1;
      @(negedge clk);
      dc_req_ready = 1'b0;
    end
    #1;
    chk({tag, " pre-reset valid"}, 64'(dc_req_valid), 64'(in_req));
    mem_read_in = 1'b0;
    reset = 1'b1;
    #1;
    check_all_zero(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t vt[13];
  vec_t r;
  int   op, rdy, rsp, fl;
  logic [1:0]  sz;
  logic [63:0] a;

  initial begin
    #2 reset = 1'b1;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    vt[0]  = mkv(1, 0, 64'h1000, 0, 3, 0, 0, 1, -1, 64'h8877665544332211,
                 4, 1, 0, 0, 1, 64'h8877665544332211, 0);
    vt[1]  = mkv(1, 0, 64'h1003, 0, 0, 0, 0, 0, -1, 64'h0000000080000000,
                 3, 1, 0, 0, 1, 64'hFFFFFFFFFFFFFF80, 0);
    vt[2]  = mkv(1, 0, 64'h1003, 0, 0, 1, 0, 0, -1, 64'h0000000080000000,
                 3, 1, 0, 0, 1, 64'h0000000000000080, 0);
    vt[3]  = mkv(0, 1, 64'h2006, 64'hBEEF, 1, 0, 3, 0, -1, 0,
                 5, 4, 8'hC0, 64'hBEEF000000000000, 0, 0, 0);
    vt[4]  = mkv(1, 0, 64'h3002, 0, 2, 0, 0, 0, -1, 0, 1, 0, 0, 0, 0, 0, 1);
    vt[5]  = mkv(1, 1, 64'h4004, 64'h77, 2, 0, 0, 0, -1, 64'h123456789ABCDEF0,
                 3, 1, 0, 0, 1, 64'h0000000012345678, 0);
    vt[6]  = mkv(1, 0, 64'h5002, 0, 1, 0, 2, 3, -1, 64'h0000000080010000,
                 8, 3, 0, 0, 1, 64'hFFFFFFFFFFFF8001, 0);
    vt[7]  = mkv(0, 1, 64'h6000, 64'hDEADBEEFCAFEF00D, 3, 0, 0, 0, -1, 0,
                 2, 1, 8'hFF, 64'hDEADBEEFCAFEF00D, 0, 0, 0);
    vt[8]  = mkv(0, 1, 64'h7007, 64'h11223344556677A5, 0, 0, 1, 0, -1, 0,
                 3, 2, 8'h80, 64'hA500000000000000, 0, 0, 0);
    vt[9]  = mkv(0, 1, 64'h8004, 64'h1, 3, 0, 0, 0, -1, 0, 1, 0, 0, 0, 0, 0, 1);
    vt[10] = mkv(1, 0, 64'h9000, 0, 3, 0, 0, 2, 3, 64'h1111, 5, 1, 0, 0, 0, 0, 0);
    vt[11] = mkv(1, 0, 64'hA000, 0, 3, 0, 2, 0, 1, 64'h2222, 5, 3, 0, 0, 0, 0, 0);
    vt[12] = mkv(1, 0, 64'hB00C, 0, 2, 1, 1, 1, -1, 64'hFEDCBA9876543210,
                 5, 2, 0, 0, 1, 64'h00000000FEDCBA98, 0);
    for (int i = 0; i < 13; i++) check_vec(vt[i], $sformatf("vec%0d", i));

    // A response with no load in flight must not produce a result.
    @(negedge clk);
    dc_resp_valid = 1'b1; dc_resp_rdata = 64'hFFFF;
    @(negedge clk);
    dc_resp_valid = 1'b0;
    #1;
    chk("stray resp", {62'd0, load_valid, stall_out}, 64'd0);

    for (int i = 0; i < 150; i++) begin
      op  = $urandom_range(0, 2);
      sz  = 2'($urandom_range(0, 3));
      a   = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      rdy = $urandom_range(0, 3);
      rsp = $urandom_range(0, 3);
      r   = model(op != 1, op != 0, a, {$urandom, $urandom}, sz, 1'($urandom), rdy, rsp, -1,
                  {$urandom, $urandom});
      if (!r.exp_mis && $urandom_range(0, 3) == 0) begin
        fl = $urandom_range(1, r.exp_stall - 1);
        r  = model(r.rd, r.wr, r.addr, r.wdata, r.size, r.uns, rdy, rsp, fl, r.rdata);
      end
      check_vec(r, $sformatf("rnd%0d", i));
    end

    reset_mid(1'b1, "rst in REQ");
    reset_mid(1'b0, "rst in WAIT");
    check_vec(vt[0], "after reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM mem_read/mem_write control outputs.
- Turns one pipeline memory request into a valid/ready transaction on the data-cache port.
- For loads, extracts the addressed byte/half/word/doubleword from the 64-bit response and extends it.
- Holds the pipeline stalled until the access completes.

Parameters:
- XLEN, 64, data width of wdata/rdata/load result
- ADDR_W, 64, address width

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  kill the instruction currently in MEM; suppresses its result
- mem_read_in  input  1  load request from EX/MEM
- mem_write_in  input  1  store request from EX/MEM
- addr_in  input  ADDR_W  effective address
- wdata_in  input  XLEN  store data, right-aligned
- size_in  input  2  0=byte 1=half 2=word 3=dword
- unsigned_in  input  1  1=zero-extend load, 0=sign-extend
- dc_req_valid  output  1  request valid to data cache
- dc_req_ready  input  1  cache accepts request
- dc_req_we  output  1  1=store
- dc_req_addr  output  ADDR_W  address, low 3 bits forced 0
- dc_req_wdata  output  XLEN  store data shifted to byte lane
- dc_req_strb  output  XLEN/8  byte enables
- dc_resp_valid  input  1  load response valid (loads only)
- dc_resp_rdata  input  XLEN  aligned doubleword
- stall_out  output  1  hold IF/ID/EX/EX-MEM registers
- load_valid  output  1  one-cycle pulse, load_data valid
- load_data  output  XLEN  extended load result
- misalign_out  output  1  one-cycle pulse, misaligned access detected

Behaviour:
- Reset: asynchronous, active-high. State=IDLE. All registered outputs 0: dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata, dc_req_strb, load_valid, load_data, misalign_out.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If (mem_read_in|mem_write_in) && !flush: latch addr, wdata, size, unsigned, we.
  - Read has priority when both inputs are high (we=0).
  - If aligned -> REQ; if misaligned -> DONE with misalign_out=1, no cache request.
  - Misaligned means addr[0]!=0 for half, addr[1:0]!=0 for word, addr[2:0]!=0 for dword.
- stall_out is combinational:
  - 1 in IDLE when a non-flushed request is present.
  - 1 in REQ and WAIT.
  - 0 in DONE.
- DONE lasts exactly one cycle, then -> IDLE. DONE never starts a request, so the EX/MEM register advances at the end of DONE without a double issue.
- REQ:
  - dc_req_valid=1; request fields stay stable until dc_req_ready.
  - On dc_req_valid && dc_req_ready: store -> DONE (posted, no response); load -> WAIT.
- Store lane/strobe: dc_req_wdata = wdata << (8*addr[2:0]); dc_req_strb = ((1<<(1<<size))-1) << addr[2:0].
- WAIT: on dc_resp_valid, select bytes at offset addr[2:0] of width 1<<size, extend per unsigned, register into load_data, -> DONE.
- load_valid=1 only in DONE, only for a load that was not killed; load_data holds its value until the next load completes.
- Flush:
  - In IDLE: blocks request capture.
  - In REQ/WAIT: sets a kill flag. The transaction still completes (valid is never dropped before ready), but load_valid and misalign_out are suppressed. Kill flag clears on entry to IDLE.
- dc_resp_valid outside WAIT is ignored.
- Reset asserted mid-transaction: immediate return to IDLE, dc_req_valid drops asynchronously. Cache-side cleanup is the cache's responsibility, since the cache shares the same reset.
- Latency:
  - Store with ready already high: 2 stall cycles (IDLE, REQ), then DONE.
  - Load: IDLE + REQ + WAIT cycles, then DONE.

Test Plan:
- Aligned dword load: addr=0x1000, size=3, ready=1, resp after 2 cycles with rdata=0x8877665544332211 -> dc_req_addr=0x1000, load_valid pulse, load_data=0x8877665544332211, stall high 4 cycles.
- Signed byte load: addr=0x1003, size=0, unsigned=0, rdata=0x00000000_80000000 -> load_data=0xFFFFFFFFFFFFFF80. Same access with unsigned=1 -> 0x80.
- Half store: addr=0x2006, size=1, wdata=0xBEEF, ready low 3 cycles -> dc_req_valid held 4 cycles with stable fields, strb=0xC0, wdata=0xBEEF<<48, stall released the cycle after the handshake.
- Misaligned word load: addr=0x3002, size=2 -> no dc_req_valid, misalign_out pulse in DONE, stall for 1 cycle only.
- Flush during WAIT -> response still consumed, load_valid stays 0, next request is accepted normally.
- Reset asserted in WAIT -> dc_req_valid=0 and all outputs 0 without a clock edge; a following load completes normally.
